// File: rtl/demux2x4_capture.sv
// Two-lane 1-of-4 slot capture: reassembles serial slots into 4-bit words.
// Optional QP0/QP1 odd-parity outputs when DEMUX2X4_PARITY_EN is defined.
module demux2x4_capture #(
  parameter bit DUP_RESTART = 1'b0
) (
  input  logic       clk,
  input  logic       CROBAR,
  input  logic       EN,
  input  logic [0:1] SEL,
  input  logic       AUTO,
  input  logic       B0,
  input  logic       B1,
  input  logic       CLR,
  output logic [0:3] Q0,
  output logic [0:3] Q1,
  output logic       VALID,
  output logic       DUP,
  output logic [0:3] FILL
`ifdef DEMUX2X4_PARITY_EN
  ,
  output logic       QP0,
  output logic       QP1
`endif
);

  logic [0:3] r_q0, r_q1, r_s0, r_s1, r_fill;
  logic [1:0] r_ph;
  logic       r_valid, r_dup;

  logic [1:0] w_k;
  logic       w_hit, w_done;
  logic [0:3] w_onehot, w_fill_wr;
  logic [0:3] w_s0_wr, w_s1_wr;

  logic [0:3] w_q0_nxt, w_q1_nxt, w_s0_nxt, w_s1_nxt;
  logic [0:3] w_fill_nxt;
  logic [1:0] w_ph_nxt;
  logic       w_valid_nxt, w_dup_nxt;

  always_comb begin
    w_k         = AUTO ? r_ph : SEL;
    w_hit       = r_fill[w_k];
    w_onehot    = '0;
    w_onehot[w_k] = 1'b1;
    w_fill_wr   = (DUP_RESTART && w_hit) ? w_onehot
                                         : (r_fill | w_onehot);
    w_s0_wr     = r_s0;
    w_s0_wr[w_k] = B0;
    w_s1_wr     = r_s1;
    w_s1_wr[w_k] = B1;
    w_done      = (w_fill_wr == 4'b1111);
  end

  always_comb begin
    w_q0_nxt    = r_q0;
    w_q1_nxt    = r_q1;
    w_s0_nxt    = r_s0;
    w_s1_nxt    = r_s1;
    w_fill_nxt  = r_fill;
    w_ph_nxt    = r_ph;
    w_valid_nxt = 1'b0;
    w_dup_nxt   = 1'b0;
    if (CLR) begin
      w_fill_nxt = '0;
      w_ph_nxt   = '0;
    end else if (EN) begin
      w_s0_nxt  = w_s0_wr;
      w_s1_nxt  = w_s1_wr;
      w_dup_nxt = w_hit;
      if (w_done) begin
        w_q0_nxt    = w_s0_wr;
        w_q1_nxt    = w_s1_wr;
        w_fill_nxt  = '0;
        w_ph_nxt    = '0;
        w_valid_nxt = 1'b1;
      end else begin
        w_fill_nxt = w_fill_wr;
        w_ph_nxt   = AUTO ? r_ph + 2'd1 : r_ph;
      end
    end
  end

  always_ff @(posedge clk or posedge CROBAR) begin
    if (CROBAR) begin
      r_q0    <= '0;
      r_q1    <= '0;
      r_s0    <= '0;
      r_s1    <= '0;
      r_fill  <= '0;
      r_ph    <= '0;
      r_valid <= 1'b0;
      r_dup   <= 1'b0;
    end else begin
      r_q0    <= w_q0_nxt;
      r_q1    <= w_q1_nxt;
      r_s0    <= w_s0_nxt;
      r_s1    <= w_s1_nxt;
      r_fill  <= w_fill_nxt;
      r_ph    <= w_ph_nxt;
      r_valid <= w_valid_nxt;
      r_dup   <= w_dup_nxt;
    end
  end

  assign Q0    = r_q0;
  assign Q1    = r_q1;
  assign VALID = r_valid;
  assign DUP   = r_dup;
  assign FILL  = r_fill;

`ifdef DEMUX2X4_PARITY_EN
  // Parity resets to 1 so it stays consistent with Q=0.
  logic r_qp0, r_qp1;

  always_ff @(posedge clk or posedge CROBAR) begin
    if (CROBAR) begin
      r_qp0 <= 1'b1;
      r_qp1 <= 1'b1;
    end else if (w_valid_nxt) begin
      r_qp0 <= ~^w_q0_nxt;
      r_qp1 <= ~^w_q1_nxt;
    end
  end

  assign QP0 = r_qp0;
  assign QP1 = r_qp1;
`endif

endmodule

// File: tb/tb_demux2x4_capture.sv
// Directed bench for demux2x4_capture; runs DUP_RESTART=0 and =1 side by side.
// Both instances share stimulus; outputs are checked against hand values.
module tb_demux2x4_capture;

  logic       clk = 1'b0;
  logic       CROBAR, EN, AUTO, B0, B1, CLR;
  logic [0:1] SEL;

  logic [0:3] q0_a, q1_a, fill_a, q0_b, q1_b, fill_b;
  logic       valid_a, dup_a, valid_b, dup_b;
`ifdef DEMUX2X4_PARITY_EN
  logic       qp0_a, qp1_a, qp0_b, qp1_b;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  demux2x4_capture #(.DUP_RESTART(1'b0)) dut_a (
    .clk(clk), .CROBAR(CROBAR), .EN(EN), .SEL(SEL), .AUTO(AUTO),
    .B0(B0), .B1(B1), .CLR(CLR),
    .Q0(q0_a), .Q1(q1_a), .VALID(valid_a), .DUP(dup_a), .FILL(fill_a)
`ifdef DEMUX2X4_PARITY_EN
    , .QP0(qp0_a), .QP1(qp1_a)
`endif
  );

  demux2x4_capture #(.DUP_RESTART(1'b1)) dut_b (
    .clk(clk), .CROBAR(CROBAR), .EN(EN), .SEL(SEL), .AUTO(AUTO),
    .B0(B0), .B1(B1), .CLR(CLR),
    .Q0(q0_b), .Q1(q1_b), .VALID(valid_b), .DUP(dup_b), .FILL(fill_b)
`ifdef DEMUX2X4_PARITY_EN
    , .QP0(qp0_b), .QP1(qp1_b)
`endif
  );

  task automatic chk(input string tag, input logic [3:0] got,
                     input logic [3:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %b, expected %b", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] s, input logic b0, input logic b1);
    EN = 1'b1; AUTO = 1'b0; CLR = 1'b0; SEL = s; B0 = b0; B1 = b1;
    step();
  endtask

  task automatic wa(input logic b0, input logic b1);
    EN = 1'b1; AUTO = 1'b1; CLR = 1'b0; SEL = 2'd0; B0 = b0; B1 = b1;
    step();
  endtask

  task automatic idle();
    EN = 1'b0; CLR = 1'b0; AUTO = 1'b0;
    step();
  endtask

  task automatic clr();
    EN = 1'b0; CLR = 1'b1;
    step();
    CLR = 1'b0;
  endtask

  logic [0:7] b1_pat;
  logic [0:7] v_pat;

  initial begin
    CROBAR = 1'b1; EN = 1'b0; AUTO = 1'b0; B0 = 1'b0; B1 = 1'b0;
    CLR = 1'b0; SEL = 2'd0;
    #12;
    CROBAR = 1'b0;
    step();
    chk("rst_q0", q0_a, 4'b0000);
    chk("rst_fill", fill_a, 4'b0000);
    chk("rst_valid", 4'(valid_a), 4'd0);
`ifdef DEMUX2X4_PARITY_EN
    chk("rst_qp0", 4'(qp0_a), 4'd1);
`endif

    // SEL mode, in order
    wr(2'd0, 1'b1, 1'b0);
    wr(2'd1, 1'b0, 1'b1);
    wr(2'd2, 1'b1, 1'b1);
    chk("sel_valid_early", 4'(valid_a), 4'd0);
    wr(2'd3, 1'b1, 1'b0);
    chk("sel_q0", q0_a, 4'b1011);
    chk("sel_q1", q1_a, 4'b0110);
    chk("sel_valid", 4'(valid_a), 4'd1);
    chk("sel_fill", fill_a, 4'b0000);
    chk("sel_q0_b", q0_b, 4'b1011);
`ifdef DEMUX2X4_PARITY_EN
    chk("sel_qp0", 4'(qp0_a), 4'd0);
    chk("sel_qp1", 4'(qp1_a), 4'd1);
`endif
    idle();
    chk("sel_valid_drop", 4'(valid_a), 4'd0);
    chk("sel_q0_hold", q0_a, 4'b1011);

    // asynchronous reset mid-word
    wr(2'd1, 1'b1, 1'b1);
    wr(2'd2, 1'b1, 1'b1);
    EN = 1'b0;
    chk("pre_rst_fill", fill_a, 4'b0110);
    #2;
    CROBAR = 1'b1;
    #1;
    chk("arst_q0", q0_a, 4'b0000);
    chk("arst_q1", q1_a, 4'b0000);
    chk("arst_fill", fill_a, 4'b0000);
    chk("arst_valid", 4'(valid_a), 4'd0);
    #1;
    CROBAR = 1'b0;
    idle();
    chk("post_rst_valid", 4'(valid_a), 4'd0);
    chk("post_rst_fill", fill_a, 4'b0000);

    // AUTO mode, two back-to-back words
    b1_pat = 8'b1010_1010;
    v_pat  = 8'b0001_0001;
    for (int i = 0; i < 8; i++) begin
      wa(1'b1, b1_pat[i]);
      chk($sformatf("auto_valid%0d", i), 4'(valid_a), 4'(v_pat[i]));
      if (v_pat[i]) begin
        chk($sformatf("auto_q0_%0d", i), q0_a, 4'b1111);
        chk($sformatf("auto_q1_%0d", i), q1_a, 4'b1010);
      end
      if (i == 4) chk("auto_fill4", fill_a, 4'b1000);
    end
    idle();
    chk("auto_valid_end", 4'(valid_a), 4'd0);

    // out-of-order with duplicate
    clr();
    wr(2'd2, 1'b0, 1'b0);
    chk("ooo_dup0", 4'(dup_a), 4'd0);
    wr(2'd2, 1'b1, 1'b0);
    chk("ooo_dup1", 4'(dup_a), 4'd1);
    chk("ooo_fill1", fill_a, 4'b0010);
    wr(2'd0, 1'b0, 1'b0);
    chk("ooo_dup2", 4'(dup_a), 4'd0);
    wr(2'd3, 1'b0, 1'b0);
    chk("ooo_fill3", fill_a, 4'b1011);
    wr(2'd1, 1'b0, 1'b0);
    chk("ooo_valid", 4'(valid_a), 4'd1);
    chk("ooo_q0", q0_a, 4'b0010);
    chk("ooo_q1", q1_a, 4'b0000);
    idle();
    chk("ooo_dup_idle", 4'(dup_a), 4'd0);

    // restart vs overwrite on duplicate
    clr();
    wr(2'd0, 1'b1, 1'b0);
    wr(2'd1, 1'b1, 1'b0);
    wr(2'd1, 1'b0, 1'b0);
    chk("rs_fill_b", fill_b, 4'b0100);
    chk("rs_fill_a", fill_a, 4'b1100);
    chk("rs_dup_b", 4'(dup_b), 4'd1);
    wr(2'd0, 1'b1, 1'b0);
    chk("rs_dup2_b", 4'(dup_b), 4'd0);
    chk("rs_dup2_a", 4'(dup_a), 4'd1);
    chk("rs_fill2_b", fill_b, 4'b1100);
    wr(2'd2, 1'b1, 1'b0);
    chk("rs_valid5_b", 4'(valid_b), 4'd0);
    wr(2'd3, 1'b0, 1'b0);
    chk("rs_valid6_b", 4'(valid_b), 4'd1);
    chk("rs_valid6_a", 4'(valid_a), 4'd1);
    chk("rs_q0_b", q0_b, 4'b1010);
    chk("rs_q0_a", q0_a, 4'b1010);

    // AUTO toggled mid-word: PH holds, SEL-filled slot becomes a dup
    clr();
    wa(1'b0, 1'b0);
    wr(2'd1, 1'b1, 1'b1);
    wa(1'b0, 1'b0);
    chk("tog_dup_a", 4'(dup_a), 4'd1);
    chk("tog_fill_a", fill_a, 4'b1100);
    chk("tog_fill_b", fill_b, 4'b0100);
    wa(1'b1, 1'b0);
    wa(1'b1, 1'b0);
    chk("tog_valid_a", 4'(valid_a), 4'd1);
    chk("tog_valid_b", 4'(valid_b), 4'd0);
    chk("tog_q0_a", q0_a, 4'b0011);
    chk("tog_fill_b2", fill_b, 4'b0111);

    // CLR wins over EN
    clr();
    wr(2'd0, 1'b1, 1'b0);
    wr(2'd1, 1'b1, 1'b0);
    wr(2'd2, 1'b1, 1'b0);
    EN = 1'b1; CLR = 1'b1; SEL = 2'd3; B0 = 1'b0; B1 = 1'b1;
    step();
    chk("clr_valid", 4'(valid_a), 4'd0);
    chk("clr_fill", fill_a, 4'b0000);
    chk("clr_q0", q0_a, 4'b0011);
    idle();
    chk("clr_valid2", 4'(valid_a), 4'd0);

    // reverse-order word for parity of 0111
    wr(2'd3, 1'b1, 1'b1);
    wr(2'd2, 1'b1, 1'b1);
    wr(2'd1, 1'b1, 1'b1);
    wr(2'd0, 1'b0, 1'b1);
    chk("rev_valid", 4'(valid_a), 4'd1);
    chk("rev_q0", q0_a, 4'b0111);
    chk("rev_q1", q1_a, 4'b1111);
`ifdef DEMUX2X4_PARITY_EN
    chk("rev_qp0", 4'(qp0_a), 4'd0);
    chk("rev_qp1", 4'(qp1_a), 4'd1);
    chk("rev_qp0_b", 4'(qp0_b), 4'd0);
`endif
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
